// File: rtl/ekf_stage_seq_if.sv
// Stage-request and nonlinear-unit handshake bundle for ekf_stage_seq.
// master = EKF controller plus nonlinear unit side; slave = the sequencer.
interface ekf_stage_seq_if #(
  parameter int NUM_STAGE = 3
);
  logic [NUM_STAGE-1:0] stage_val;
  logic [NUM_STAGE-1:0] stage_rdy;
  logic [NUM_STAGE-1:0] nonlinear_s_val;
  logic [NUM_STAGE-1:0] nonlinear_m_rdy;
  logic [NUM_STAGE-1:0] nonlinear_s_rdy;
  logic [NUM_STAGE-1:0] nonlinear_m_val;

  modport master (
    output stage_val, nonlinear_s_val, nonlinear_s_rdy,
    input  stage_rdy, nonlinear_m_rdy, nonlinear_m_val
  );

  modport slave (
    input  stage_val, nonlinear_s_val, nonlinear_s_rdy,
    output stage_rdy, nonlinear_m_rdy, nonlinear_m_val
  );
endinterface

// File: rtl/ekf_stage_seq.sv
// EKF-SLAM stage sequencer: PRE -> NL_RX -> NL_TX -> POST(2N+3) -> DONE per one-hot stage.
// Optional NL-handshake watchdog enabled by defining EKF_STAGE_SEQ_TIMEOUT_EN.
module ekf_stage_seq #(
  parameter int NUM_STAGE   = 3,
  parameter int ROW_LEN     = 10,
  parameter int CNT_DW      = 16,
  parameter int PRE_CYC     = 4,
  parameter int LK_STAGE    = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  ekf_stage_seq_if.slave       bus,
  input  logic [ROW_LEN-1:0]   landmark_num,
  input  logic [ROW_LEN-1:0]   l_k,
  output logic [NUM_STAGE-1:0] cur_stage,
  output logic [2:0]           phase,
  output logic [CNT_DW-1:0]    seq_cnt,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_NL_RX = 3'd2,
    S_NL_TX = 3'd3,
    S_POST  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_DW-1:0] PRE_LAST = CNT_DW'(PRE_CYC - 1);

  state_t               state_q, state_d;
  logic [NUM_STAGE-1:0] stage_q, stage_d;
  logic [CNT_DW-1:0]    cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [ROW_LEN-1:0]   lm_q, lk_q;
  logic                 capture;

  logic [NUM_STAGE-1:0] req_low;
  logic                 req_multi;
  logic [ROW_LEN-1:0]   post_n;
  logic [CNT_DW-1:0]    post_last;
  logic                 wd_hit;

  // Two's-complement trick isolates the lowest requested stage.
  assign req_low   = bus.stage_val & (~bus.stage_val + NUM_STAGE'(1));
  assign req_multi = (bus.stage_val & (bus.stage_val - NUM_STAGE'(1))) != '0;

  assign post_n    = stage_q[LK_STAGE] ? lk_q : lm_q;
  assign post_last = (CNT_DW'(post_n) << 1) + CNT_DW'(2);

`ifdef EKF_STAGE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  // Counts NL_RX + NL_TX cycles; cleared whenever outside the NL states.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wd_q <= '0;
    end else if (state_q == S_NL_RX || state_q == S_NL_TX) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end

  assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out; constant-false still references the parameter.
  assign wd_hit = (TIMEOUT_CYC < 0);
`endif

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = '0;
    err_d   = err_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.stage_val != '0) begin
          state_d = S_PRE;
          stage_d = req_low;
          capture = 1'b1;
          if (req_multi) err_d = 1'b1;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) state_d = S_NL_RX;
        else                   cnt_d   = cnt_q + CNT_DW'(1);
      end
      S_NL_RX: begin
        if ((bus.nonlinear_s_val & stage_q) != '0) begin
          state_d = S_NL_TX;
        end else if (wd_hit) begin
          state_d = S_IDLE;
          stage_d = '0;
          err_d   = 1'b1;
        end
      end
      S_NL_TX: begin
        if ((bus.nonlinear_s_rdy & stage_q) != '0) begin
          state_d = S_POST;
        end else if (wd_hit) begin
          state_d = S_IDLE;
          stage_d = '0;
          err_d   = 1'b1;
        end
      end
      S_POST: begin
        if (cnt_q == post_last) state_d = S_DONE;
        else                    cnt_d   = cnt_q + CNT_DW'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      lm_q    <= '0;
      lk_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (capture) begin
        lm_q <= landmark_num;
        lk_q <= l_k;
      end
    end
  end

  assign bus.stage_rdy       = (state_q == S_IDLE)  ? '1 : '0;
  assign bus.nonlinear_m_rdy = (state_q == S_NL_RX) ? stage_q : '0;
  assign bus.nonlinear_m_val = (state_q == S_NL_TX) ? stage_q : '0;
  assign cur_stage           = stage_q;
  assign phase               = state_q;
  assign seq_cnt             = cnt_q;
  assign done                = (state_q == S_DONE);
  assign err                 = err_q;

endmodule
